// File: rtl/sequenciador_contador74163_pkg.sv
// Shared types for the 74163 sequencer: FSM encoding, counter pin bundle and count limit.
package sequenciador_contador74163_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_COUNT = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   typedef struct packed {
      logic       clr_n;
      logic       ld_n;
      logic       enp;
      logic       ent;
      logic [3:0] data;
   } pins_t;

   localparam pins_t IDLE_PINS = '{clr_n: 1'b1, ld_n: 1'b1, enp: 1'b0, ent: 1'b0, data: 4'h0};
   localparam logic [3:0] COUNT_MAX = 4'd15;

endpackage

// File: rtl/sequenciador_contador74163_modelo.sv
// Shadow 74163: tracks the count the real part should hold, same edge, same priorities.
// Zero latency: exp changes on the edge the counter acts on its pins.
module modelo_contador74163
   import sequenciador_contador74163_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       ld,
   input  logic       en,
   input  logic [3:0] d,
   output logic [3:0] exp,
   output logic       rco_exp
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp <= 4'd0;
      end else if (clr) begin
         exp <= 4'd0;
      end else if (ld) begin
         exp <= d;
      end else if (en) begin
         exp <= exp + 4'd1;
      end
   end

   // Ripple carry is combinational on the enable, like the real part.
   assign rco_exp = en && (exp == COUNT_MAX);

endmodule

// File: rtl/sequenciador_contador74163.sv
// Drives a 74163 through clear -> optional load -> count and checks Q/RCO every cycle.
// start-to-done: 1 + use_load + steps + paused cycles, then a one-cycle done pulse.
module sequenciador_contador74163
   import sequenciador_contador74163_pkg::*;
(
   input  logic       CLK,
   input  logic       CLR_N,
   input  logic       start,
   input  logic       use_load,
   input  logic [3:0] load_val,
   input  logic [7:0] steps,
   input  logic       pause,
   input  logic [3:0] q,
   input  logic       rco,
   output logic       clr_n_o,
   output logic       ld_n_o,
   output logic       enp_o,
   output logic       ent_o,
   output logic [3:0] data_o,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] exp_q,
   output logic [3:0] got_q,
   output logic [3:0] wraps
);

   state_t     state;
   state_t     next_state;
   pins_t      pins;
   logic       use_load_r;
   logic [3:0] load_val_r;
   logic [7:0] rem;
   logic       chk_en;
   logic [3:0] exp_cnt;
   logic       rco_exp;
   logic       mismatch;
   logic       launch;
   logic       step;

   modelo_contador74163 u_modelo (
      .clk     (CLK),
      .rst_n   (CLR_N),
      .clr     (!pins.clr_n),
      .ld      (!pins.ld_n),
      .en      (pins.enp && pins.ent),
      .d       (pins.data),
      .exp     (exp_cnt),
      .rco_exp (rco_exp)
   );

   assign mismatch = (chk_en && (q != exp_cnt)) || (rco != rco_exp);
   assign step     = (state == S_COUNT) && !pause;
   assign launch   = (next_state == S_CLEAR);

   always_comb begin
      pins       = IDLE_PINS;
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) next_state = S_CLEAR;
         end
         S_CLEAR: begin
            pins.clr_n = 1'b0;
            if (use_load_r)       next_state = S_LOAD;
            else if (rem == 8'd0) next_state = S_DONE;
            else                  next_state = S_COUNT;
         end
         S_LOAD: begin
            pins.ld_n  = 1'b0;
            pins.data  = load_val_r;
            next_state = (rem == 8'd0) ? S_DONE : S_COUNT;
         end
         S_COUNT: begin
            pins.enp = 1'b1;
            pins.ent = !pause;
            if (!pause && (rem == 8'd1)) next_state = S_DONE;
         end
         S_DONE: begin
            next_state = start ? S_CLEAR : S_IDLE;
         end
         S_ERROR: begin
            if (start) next_state = S_CLEAR;
         end
         default: next_state = S_IDLE;
      endcase
      // A failed check wins over every other transition, including COUNT->DONE.
      if (mismatch) next_state = S_ERROR;
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state      <= S_IDLE;
         use_load_r <= 1'b0;
         load_val_r <= 4'd0;
         rem        <= 8'd0;
         chk_en     <= 1'b0;
         error      <= 1'b0;
         exp_q      <= 4'd0;
         got_q      <= 4'd0;
         wraps      <= 4'd0;
      end else begin
         state <= next_state;

         if (launch) begin
            use_load_r <= use_load;
            load_val_r <= load_val;
            rem        <= steps;
         end else if (step) begin
            rem <= rem - 8'd1;
         end

         if ((next_state == S_ERROR) || (state == S_IDLE) || (state == S_ERROR)) begin
            chk_en <= 1'b0;
         end else if (state == S_CLEAR) begin
            chk_en <= 1'b1;
         end

         // Only the first mismatch is recorded; restart from ERROR wipes it.
         if (mismatch && !error) begin
            error <= 1'b1;
            exp_q <= exp_cnt;
            got_q <= q;
         end else if ((state == S_ERROR) && launch) begin
            error <= 1'b0;
            exp_q <= 4'd0;
            got_q <= 4'd0;
         end

         if (launch) begin
            wraps <= 4'd0;
         end else if (step && (exp_cnt == COUNT_MAX) && (wraps != 4'd15)) begin
            wraps <= wraps + 4'd1;
         end
      end
   end

   assign clr_n_o = pins.clr_n;
   assign ld_n_o  = pins.ld_n;
   assign enp_o   = pins.enp;
   assign ent_o   = pins.ent;
   assign data_o  = pins.data;
   assign busy    = (state == S_CLEAR) || (state == S_LOAD) || (state == S_COUNT);
   assign done    = (state == S_DONE);

endmodule

// File: tb/tb_sequenciador_contador74163.sv
// Directed bench: sequencer driving a behavioural 74163 with an optional QB stuck-at-0 fault.
module tb_sequenciador_contador74163;

   logic       CLK = 1'b0;
   logic       CLR_N = 1'b0;
   logic       start = 1'b0;
   logic       use_load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [7:0] steps = 8'd0;
   logic       pause = 1'b0;
   logic [3:0] q;
   logic       rco;
   logic       clr_n_o, ld_n_o, enp_o, ent_o;
   logic [3:0] data_o;
   logic       busy, done, error;
   logic [3:0] exp_q, got_q, wraps;

   logic [3:0] cnt = 4'd0;
   logic       fault = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 CLK = ~CLK;

   // Behavioural 74163 sharing the clock.
   always @(posedge CLK) begin
      if (!clr_n_o)           cnt <= 4'd0;
      else if (!ld_n_o)       cnt <= data_o;
      else if (enp_o && ent_o) cnt <= cnt + 4'd1;
   end
   assign q   = fault ? (cnt & 4'b1101) : cnt;
   assign rco = ent_o && (cnt == 4'd15);

   sequenciador_contador74163 dut (
      .CLK(CLK), .CLR_N(CLR_N), .start(start), .use_load(use_load), .load_val(load_val),
      .steps(steps), .pause(pause), .q(q), .rco(rco), .clr_n_o(clr_n_o), .ld_n_o(ld_n_o),
      .enp_o(enp_o), .ent_o(ent_o), .data_o(data_o), .busy(busy), .done(done), .error(error),
      .exp_q(exp_q), .got_q(got_q), .wraps(wraps)
   );

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic launch(input logic ul, input logic [3:0] lv, input logic [7:0] st);
      start = 1'b1; use_load = ul; load_val = lv; steps = st;
      cyc();
      start = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_chk++; if ({clr_n_o, ld_n_o, enp_o, ent_o, data_o} !== 8'hC0) begin n_fail++; $display("FAIL reset_pins: got %h want c0", {clr_n_o, ld_n_o, enp_o, ent_o, data_o}); end
      n_chk++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
      n_chk++; if ({exp_q, got_q, wraps} !== 12'h000) begin n_fail++; $display("FAIL reset_captures: got %h want 000", {exp_q, got_q, wraps}); end
      @(negedge CLK); CLR_N = 1'b1;
      cyc(); cyc();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic_count();
      launch(1'b0, 4'd0, 8'd5);
      n_chk++; if ({clr_n_o, busy} !== 2'b01) begin n_fail++; $display("FAIL basic_clear: got %b want 01", {clr_n_o, busy}); end
      for (int i = 0; i < 5; i++) begin
         cyc();
         start = (i == 2);  // must be ignored while busy
         #1;
         n_chk++; if (q !== 4'(i)) begin n_fail++; $display("FAIL basic_q%0d: got %0d want %0d", i, q, i); end
         n_chk++; if ({ent_o, done} !== 2'b10) begin n_fail++; $display("FAIL basic_ent_done%0d: got %b want 10", i, {ent_o, done}); end
      end
      start = 1'b0;
      cyc();
      n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
      n_chk++; if (q !== 4'd5) begin n_fail++; $display("FAIL basic_final_q: got %0d want 5", q); end
      n_chk++; if ({error, wraps} !== 5'd0) begin n_fail++; $display("FAIL basic_err_wraps: got %b want 00000", {error, wraps}); end
      cyc();
      n_chk++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done: got %b want 00", {done, busy}); end
   endtask

   task automatic test_load_rco();
      launch(1'b1, 4'd10, 8'd5);
      cyc();
      n_chk++; if ({ld_n_o, data_o} !== 5'b0_1010) begin n_fail++; $display("FAIL load_pins: got %b want 01010", {ld_n_o, data_o}); end
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_chk++; if ({q, rco} !== {4'(10 + i), 1'b0}) begin n_fail++; $display("FAIL load_q%0d: got q=%0d rco=%b want q=%0d rco=0", i, q, rco, 10 + i); end
      end
      cyc();
      n_chk++; if ({done, q, wraps} !== {1'b1, 4'd15, 4'd0}) begin n_fail++; $display("FAIL load_done: got done=%b q=%0d wraps=%0d want 1/15/0", done, q, wraps); end
      launch(1'b1, 4'd15, 8'd1);
      cyc(); cyc();
      n_chk++; if ({q, ent_o, rco} !== {4'd15, 2'b11}) begin n_fail++; $display("FAIL rco_at_15: got q=%0d ent=%b rco=%b want 15/1/1", q, ent_o, rco); end
      cyc();
      n_chk++; if ({done, q, wraps} !== {1'b1, 4'd0, 4'd1}) begin n_fail++; $display("FAIL wrap_once: got done=%b q=%0d wraps=%0d want 1/0/1", done, q, wraps); end
   endtask

   task automatic test_pause();
      launch(1'b1, 4'd13, 8'd5);
      cyc(); cyc(); cyc();         // LOAD, q=13, q=14
      for (int i = 0; i < 2; i++) begin
         cyc();
         pause = 1'b1;
         #1;
         n_chk++; if ({q, ent_o, rco, done} !== {4'd15, 3'b000}) begin n_fail++; $display("FAIL pause_hold%0d: got q=%0d ent=%b rco=%b done=%b want 15/0/0/0", i, q, ent_o, rco, done); end
      end
      cyc();
      pause = 1'b0;
      #1;
      n_chk++; if ({q, rco} !== {4'd15, 1'b1}) begin n_fail++; $display("FAIL pause_resume: got q=%0d rco=%b want 15/1", q, rco); end
      cyc(); cyc();
      n_chk++; if ({q, done} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL pause_late: got q=%0d done=%b want 1/0", q, done); end
      cyc();
      n_chk++; if ({done, q, wraps} !== {1'b1, 4'd2, 4'd1}) begin n_fail++; $display("FAIL pause_done: got done=%b q=%0d wraps=%0d want 1/2/1", done, q, wraps); end
   endtask

   task automatic test_long_count();
      launch(1'b0, 4'd0, 8'd40);
      for (int i = 0; i < 40; i++) cyc();
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL long_early_done: got %b want 0", done); end
      cyc();
      n_chk++; if ({done, q, wraps, error} !== {1'b1, 4'd8, 4'd2, 1'b0}) begin n_fail++; $display("FAIL long_done: got done=%b q=%0d wraps=%0d err=%b want 1/8/2/0", done, q, wraps, error); end
   endtask

   task automatic test_back_to_back();
      launch(1'b0, 4'd0, 8'd0);
      cyc();
      n_chk++; if ({done, q} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL zero_steps: got done=%b q=%0d want 1/0", done, q); end
      start = 1'b1; use_load = 1'b0; steps = 8'd2;
      cyc();
      start = 1'b0;
      #1;
      n_chk++; if ({clr_n_o, busy} !== 2'b01) begin n_fail++; $display("FAIL b2b_clear: got %b want 01", {clr_n_o, busy}); end
      cyc(); cyc(); cyc();
      n_chk++; if ({done, q} !== {1'b1, 4'd2}) begin n_fail++; $display("FAIL b2b_done: got done=%b q=%0d want 1/2", done, q); end
      cyc();
   endtask

   task automatic test_fault();
      launch(1'b0, 4'd0, 8'd3);
      cyc();
      fault = 1'b1;
      #1;
      n_chk++; if (q !== 4'd0) begin n_fail++; $display("FAIL fault_q0: got %0d want 0", q); end
      cyc(); cyc();
      n_chk++; if ({error, busy} !== 2'b01) begin n_fail++; $display("FAIL fault_pre: got err=%b busy=%b want 0/1", error, busy); end
      cyc();
      n_chk++; if ({error, done, busy} !== 3'b100) begin n_fail++; $display("FAIL fault_flags: got %b want 100", {error, done, busy}); end
      n_chk++; if ({exp_q, got_q} !== {4'd2, 4'd0}) begin n_fail++; $display("FAIL fault_capture: got exp_q=%0d got_q=%0d want 2/0", exp_q, got_q); end
      n_chk++; if ({clr_n_o, ld_n_o, enp_o, ent_o, data_o} !== 8'hC0) begin n_fail++; $display("FAIL fault_pins: got %h want c0", {clr_n_o, ld_n_o, enp_o, ent_o, data_o}); end
      cyc(); cyc();
      n_chk++; if ({error, exp_q} !== {1'b1, 4'd2}) begin n_fail++; $display("FAIL fault_sticky: got err=%b exp_q=%0d want 1/2", error, exp_q); end
      fault = 1'b0;
      launch(1'b0, 4'd0, 8'd2);
      n_chk++; if ({error, exp_q, got_q, busy} !== {1'b0, 8'h00, 1'b1}) begin n_fail++; $display("FAIL fault_restart: got err=%b exp_q=%0d got_q=%0d busy=%b want 0/0/0/1", error, exp_q, got_q, busy); end
      cyc(); cyc(); cyc();
      n_chk++; if ({done, q, error} !== {1'b1, 4'd2, 1'b0}) begin n_fail++; $display("FAIL fault_recover: got done=%b q=%0d err=%b want 1/2/0", done, q, error); end
      cyc();
   endtask

   task automatic test_async_reset();
      launch(1'b1, 4'd14, 8'd10);
      cyc(); cyc(); cyc(); cyc();    // LOAD, q=14, q=15, q=0
      n_chk++; if ({busy, q, wraps} !== {1'b1, 4'd0, 4'd1}) begin n_fail++; $display("FAIL arst_pre: got busy=%b q=%0d wraps=%0d want 1/0/1", busy, q, wraps); end
      CLR_N = 1'b0;
      #1;
      n_chk++; if ({clr_n_o, ld_n_o, enp_o, ent_o, data_o} !== 8'hC0) begin n_fail++; $display("FAIL arst_pins: got %h want c0", {clr_n_o, ld_n_o, enp_o, ent_o, data_o}); end
      n_chk++; if ({busy, done, error, exp_q, got_q, wraps} !== 15'd0) begin n_fail++; $display("FAIL arst_outputs: got %h want 0", {busy, done, error, exp_q, got_q, wraps}); end
      #2;
      CLR_N = 1'b1;
      cyc();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_idle: got busy=%b want 0", busy); end
      launch(1'b0, 4'd0, 8'd3);
      cyc(); cyc(); cyc(); cyc();
      n_chk++; if ({done, q, error} !== {1'b1, 4'd3, 1'b0}) begin n_fail++; $display("FAIL arst_rerun: got done=%b q=%0d err=%b want 1/3/0", done, q, error); end
   endtask

   initial begin
      test_reset();
      test_basic_count();
      test_load_rco();
      test_pause();
      test_long_count();
      test_back_to_back();
      test_fault();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
